// File: rtl/bridge_pkg.sv
// Shared definitions for the bridge data-port arbiter and the bridge itself.
//   - address map bounds (data memory, timer 0, timer 1)
//   - arbiter FSM state encoding
//   - owner encoding driven on the arbiter's owner output
//   - in_range helper used by the address checker
package bridge_pkg;

    localparam logic [31:0] DM_LO = 32'h0000_0000;
    localparam logic [31:0] DM_HI = 32'h0000_2FFF;
    localparam logic [31:0] T0_LO = 32'h0000_7F00;
    localparam logic [31:0] T0_HI = 32'h0000_7F0B;
    localparam logic [31:0] T1_LO = 32'h0000_7F10;
    localparam logic [31:0] T1_HI = 32'h0000_7F1B;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_e;

    localparam logic [1:0] OWN_NONE = 2'b00;
    localparam logic [1:0] OWN_M0   = 2'b01;
    localparam logic [1:0] OWN_M1   = 2'b10;

    function automatic logic in_range(input logic [31:0] a,
                                      input logic [31:0] lo,
                                      input logic [31:0] hi);
        return (a >= lo) && (a <= hi);
    endfunction

endpackage

// File: rtl/bridge_arbiter_if.sv
// One bus master's connection to the bridge arbiter.
//   req/addr/wdata/we/lock : request and payload, held by the master until ack
//   ack/err/rdata          : one-cycle response from the arbiter
// modport master : the requesting engine (CPU mem stage, DMA, debug)
// modport slave  : the arbiter side
interface bridge_arbiter_if;
    logic        req;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        we;
    logic        lock;
    logic        ack;
    logic        err;
    logic [31:0] rdata;

    modport master (output req, addr, wdata, we, lock,
                    input  ack, err, rdata);
    modport slave  (input  req, addr, wdata, we, lock,
                    output ack, err, rdata);
endinterface

// File: rtl/bridge_addr_check.sv
// Combinational access check for the bridge address map.
//   addr_i : byte address
//   ok_o   : 1 when the address is word aligned and falls in DM, T0 or T1
// Shared between the arbiter and the bridge so both agree on the map.
module bridge_addr_check
    import bridge_pkg::*;
(
    input  logic [31:0] addr_i,
    output logic        ok_o
);
    logic mapped;

    assign mapped = in_range(addr_i, DM_LO, DM_HI) |
                    in_range(addr_i, T0_LO, T0_HI) |
                    in_range(addr_i, T1_LO, T1_HI);

    assign ok_o = (addr_i[1:0] == 2'b00) & mapped;
endmodule

// File: rtl/bridge_arbiter.sv
// Two-master round-robin arbiter in front of the bridge data port.
//   clk, reset_n   : clock, synchronous active-low reset
//   m0, m1         : master ports (m0 = CPU memory stage, m1 = DMA/debug)
//   br_addr/wdata  : bridge address / write data, non-zero only in ACCESS
//   br_we          : bridge write strobe, one cycle per accepted valid write
//   br_rdata       : bridge read data (combinational in the bridge)
//   owner          : 00 idle, 01 master 0, 10 master 1
// Each transaction takes IDLE -> ACCESS -> RESP. A master asserting lock
// keeps ownership for up to MAX_BURST grants while the other master waits.
module bridge_arbiter
    import bridge_pkg::*;
#(
    parameter int MAX_BURST = 4
) (
    input  logic               clk,
    input  logic               reset_n,
    bridge_arbiter_if.slave    m0,
    bridge_arbiter_if.slave    m1,
    output logic [31:0]        br_addr,
    output logic [31:0]        br_wdata,
    output logic               br_we,
    input  logic [31:0]        br_rdata,
    output logic [1:0]         owner
);
    localparam logic [3:0] BMAX = 4'(MAX_BURST);

    state_e      state_q, state_d;
    logic [1:0]  own_q, own_d;
    logic        last_q, last_d;     // 1 = master 1 granted last
    logic        hold_q, hold_d;
    logic [3:0]  burst_q, burst_d;
    logic [31:0] addr_q, wdata_q, rdata_q;
    logic        we_q, ok_q;

    logic        holder_req, other_req, keep, gnt_v, gnt_m1, sel_ok;
    logic [31:0] sel_addr;

    // Grant selection, only acted on in IDLE. keep = holder retains the port.
    always_comb begin
        holder_req = (own_q == OWN_M1) ? m1.req : m0.req;
        other_req  = (own_q == OWN_M1) ? m0.req : m1.req;
        keep       = hold_q & holder_req & ~((burst_q == BMAX) & other_req);
        gnt_v      = 1'b0;
        gnt_m1     = 1'b0;
        if (keep) begin
            gnt_v  = 1'b1;
            gnt_m1 = (own_q == OWN_M1);
        end else if (m0.req && m1.req) begin
            // Burst expiry also lands here: the holder was granted last,
            // so the tie-break hands the port to the waiting master.
            gnt_v  = 1'b1;
            gnt_m1 = ~last_q;
        end else if (m0.req) begin
            gnt_v  = 1'b1;
        end else if (m1.req) begin
            gnt_v  = 1'b1;
            gnt_m1 = 1'b1;
        end
    end

    assign sel_addr = gnt_m1 ? m1.addr : m0.addr;

    bridge_addr_check u_chk (
        .addr_i (sel_addr),
        .ok_o   (sel_ok)
    );

    always_comb begin
        state_d = state_q;
        own_d   = own_q;
        last_d  = last_q;
        hold_d  = hold_q;
        burst_d = burst_q;
        case (state_q)
            IDLE: begin
                // Losing the hold (holder idle or burst expired) restarts
                // the burst count; a kept hold leaves it untouched.
                if (!keep) begin
                    hold_d  = 1'b0;
                    burst_d = 4'd0;
                end
                if (gnt_v) begin
                    state_d = ACCESS;
                    own_d   = gnt_m1 ? OWN_M1 : OWN_M0;
                    last_d  = gnt_m1;
                end
            end
            ACCESS: state_d = RESP;
            RESP: begin
                state_d = IDLE;
                if ((own_q == OWN_M1) ? m1.lock : m0.lock) begin
                    hold_d  = 1'b1;
                    burst_d = (burst_q == BMAX) ? burst_q : burst_q + 4'd1;
                end else begin
                    hold_d  = 1'b0;
                    burst_d = 4'd0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
            own_q   <= OWN_NONE;
            last_q  <= 1'b1;
            hold_q  <= 1'b0;
            burst_q <= 4'd0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            we_q    <= 1'b0;
            ok_q    <= 1'b0;
            rdata_q <= 32'd0;
        end else begin
            state_q <= state_d;
            own_q   <= own_d;
            last_q  <= last_d;
            hold_q  <= hold_d;
            burst_q <= burst_d;
            if (state_q == IDLE && gnt_v) begin
                addr_q  <= sel_addr;
                wdata_q <= gnt_m1 ? m1.wdata : m0.wdata;
                we_q    <= gnt_m1 ? m1.we : m0.we;
                ok_q    <= sel_ok;
            end
            if (state_q == ACCESS)
                rdata_q <= (ok_q & ~we_q) ? br_rdata : 32'd0;
        end
    end

    logic in_acc, in_resp;
    assign in_acc  = (state_q == ACCESS);
    assign in_resp = (state_q == RESP);

    assign br_addr  = in_acc ? addr_q  : 32'd0;
    assign br_wdata = in_acc ? wdata_q : 32'd0;
    assign br_we    = in_acc & we_q & ok_q;
    assign owner    = (state_q == IDLE) ? OWN_NONE : own_q;

    assign m0.ack   = in_resp & (own_q == OWN_M0);
    assign m0.err   = m0.ack & ~ok_q;
    assign m0.rdata = m0.ack ? rdata_q : 32'd0;
    assign m1.ack   = in_resp & (own_q == OWN_M1);
    assign m1.err   = m1.ack & ~ok_q;
    assign m1.rdata = m1.ack ? rdata_q : 32'd0;
endmodule

// File: tb/tb_bridge_arbiter.sv
// Directed bench for bridge_arbiter: reset, single read, alternation,
// error responses, lock bursts, holder drop and reset during ACCESS.
module tb_bridge_arbiter;
    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] br_addr, br_wdata, br_rdata;
    logic        br_we;
    logic [1:0]  owner;
    int          n_cmp = 0;
    int          n_bad = 0;

    bridge_arbiter_if m0_if ();
    bridge_arbiter_if m1_if ();

    bridge_arbiter #(.MAX_BURST(4)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .m0       (m0_if),
        .m1       (m1_if),
        .br_addr  (br_addr),
        .br_wdata (br_wdata),
        .br_we    (br_we),
        .br_rdata (br_rdata),
        .owner    (owner)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
    endtask

    initial begin
        reset_n = 1'b0;
        br_rdata = 32'd0;
        m0_if.req = 0; m0_if.addr = 0; m0_if.wdata = 0; m0_if.we = 0; m0_if.lock = 0;
        m1_if.req = 0; m1_if.addr = 0; m1_if.wdata = 0; m1_if.we = 0; m1_if.lock = 0;

        // Reset state
        do_reset();
        chk("rst_owner", 32'(owner), 32'd0);
        chk("rst_br_addr", br_addr, 32'd0);
        chk("rst_br_we", 32'(br_we), 32'd0);
        chk("rst_m0_ack", 32'(m0_if.ack), 32'd0);
        chk("rst_m1_ack", 32'(m1_if.ack), 32'd0);
        chk("rst_m0_rdata", m0_if.rdata, 32'd0);

        // M0 read of timer 0
        br_rdata = 32'h1234_5678;
        m0_if.req = 1; m0_if.addr = 32'h7F04; m0_if.we = 0;
        tick();
        chk("rd_br_addr", br_addr, 32'h7F04);
        chk("rd_br_we", 32'(br_we), 32'd0);
        chk("rd_owner", 32'(owner), 32'd1);
        tick();
        chk("rd_m0_ack", 32'(m0_if.ack), 32'd1);
        chk("rd_m0_rdata", m0_if.rdata, 32'h1234_5678);
        chk("rd_m0_err", 32'(m0_if.err), 32'd0);
        chk("rd_m1_ack", 32'(m1_if.ack), 32'd0);
        tick();
        m0_if.req = 0;
        chk("rd_idle_ack", 32'(m0_if.ack), 32'd0);
        chk("rd_idle_owner", 32'(owner), 32'd0);

        // Alternating writes from both masters (fresh reset: M0 wins first tie)
        do_reset();
        m0_if.req = 1; m0_if.addr = 32'h0010; m0_if.wdata = 32'hAAAA_0000; m0_if.we = 1;
        m1_if.req = 1; m1_if.addr = 32'h7F10; m1_if.wdata = 32'hBBBB_0001; m1_if.we = 1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("alt_owner", 32'(owner), (i % 2 == 0) ? 32'd1 : 32'd2);
            chk("alt_br_we", 32'(br_we), 32'd1);
            chk("alt_br_addr", br_addr, (i % 2 == 0) ? 32'h0010 : 32'h7F10);
            chk("alt_br_wdata", br_wdata, (i % 2 == 0) ? 32'hAAAA_0000 : 32'hBBBB_0001);
            tick();
            chk("alt_m0_ack", 32'(m0_if.ack), (i % 2 == 0) ? 32'd1 : 32'd0);
            chk("alt_m1_ack", 32'(m1_if.ack), (i % 2 == 0) ? 32'd0 : 32'd1);
            chk("alt_resp_we", 32'(br_we), 32'd0);
            tick();
            chk("alt_idle_we", 32'(br_we), 32'd0);
        end
        m0_if.req = 0; m1_if.req = 0;

        // Errors: M0 misaligned read, M1 write to the hole (last grant M1 -> M0 first)
        br_rdata = 32'hDEAD_BEEF;
        m0_if.req = 1; m0_if.addr = 32'h0002; m0_if.we = 0;
        m1_if.req = 1; m1_if.addr = 32'h7F0C; m1_if.wdata = 32'h1111_2222; m1_if.we = 1;
        tick();
        chk("err0_owner", 32'(owner), 32'd1);
        chk("err0_br_we", 32'(br_we), 32'd0);
        tick();
        chk("err0_ack", 32'(m0_if.ack), 32'd1);
        chk("err0_err", 32'(m0_if.err), 32'd1);
        chk("err0_rdata", m0_if.rdata, 32'd0);
        tick();
        m0_if.req = 0;
        tick();
        chk("err1_owner", 32'(owner), 32'd2);
        chk("err1_br_we", 32'(br_we), 32'd0);
        tick();
        chk("err1_ack", 32'(m1_if.ack), 32'd1);
        chk("err1_err", 32'(m1_if.err), 32'd1);
        chk("err1_rdata", m1_if.rdata, 32'd0);
        tick();
        m1_if.req = 0;

        // Lock burst: M0 locked, M1 waiting -> 4 M0 grants then M1
        br_rdata = 32'h0BAD_F00D;
        m0_if.req = 1; m0_if.addr = 32'h0100; m0_if.we = 0; m0_if.lock = 1;
        m1_if.req = 1; m1_if.addr = 32'h0200; m1_if.we = 0; m1_if.lock = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("burst_owner", 32'(owner), 32'd1);
            tick();
            chk("burst_m0_ack", 32'(m0_if.ack), 32'd1);
            chk("burst_m1_ack", 32'(m1_if.ack), 32'd0);
            tick();
        end
        tick();
        chk("burst_sw_owner", 32'(owner), 32'd2);
        tick();
        chk("burst_sw_ack", 32'(m1_if.ack), 32'd1);
        chk("burst_sw_rdata", m1_if.rdata, 32'h0BAD_F00D);
        tick();
        m1_if.req = 0;

        // M1 idle: locked M0 keeps the port past MAX_BURST
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("sat_owner", 32'(owner), 32'd1);
            tick();
            chk("sat_m0_ack", 32'(m0_if.ack), 32'd1);
            tick();
        end

        // Holder drops req with hold set and M1 requesting
        m0_if.lock = 0;
        tick(); tick(); tick();       // unlocked transaction clears hold
        m0_if.lock = 1;
        tick(); tick();
        chk("drop_pre_ack", 32'(m0_if.ack), 32'd1);
        tick();
        chk("drop_hold_set", 32'(dut.hold_q), 32'd1);
        m0_if.req = 0;
        m1_if.req = 1; m1_if.addr = 32'h0300;
        tick();
        chk("drop_owner", 32'(owner), 32'd2);
        chk("drop_burst", 32'(dut.burst_q), 32'd0);
        tick();
        chk("drop_m1_ack", 32'(m1_if.ack), 32'd1);
        tick();
        m1_if.req = 0; m0_if.lock = 0;

        // Reset during ACCESS of an M1 write
        m1_if.req = 1; m1_if.addr = 32'h0020; m1_if.wdata = 32'h0000_0055; m1_if.we = 1;
        tick();
        chk("rstm_acc_owner", 32'(owner), 32'd2);
        chk("rstm_acc_we", 32'(br_we), 32'd1);
        reset_n = 1'b0;
        m0_if.req = 1; m0_if.addr = 32'h0040; m0_if.we = 0;
        tick();
        chk("rstm_owner", 32'(owner), 32'd0);
        chk("rstm_br_we", 32'(br_we), 32'd0);
        chk("rstm_br_addr", br_addr, 32'd0);
        chk("rstm_m1_ack", 32'(m1_if.ack), 32'd0);
        chk("rstm_m0_ack", 32'(m0_if.ack), 32'd0);
        reset_n = 1'b1;
        tick();
        chk("rstm_tie_owner", 32'(owner), 32'd1);
        tick();
        chk("rstm_m0_ack2", 32'(m0_if.ack), 32'd1);
        chk("rstm_m1_ack2", 32'(m1_if.ack), 32'd0);
        chk("rstm_m0_rdata", m0_if.rdata, 32'h0BAD_F00D);
        tick();
        m0_if.req = 0; m1_if.req = 0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/bridge_arbiter.md
# bridge_arbiter

Two-master arbiter in front of the system bridge's data port (bridge address/write-data/write-enable/read-data). Shares that single port between the CPU memory stage (master 0) and a second bus master such as a DMA/debug engine (master 1). Uses round-robin arbitration with optional bounded lock bursts. Registers each transaction, rejects unmapped or misaligned accesses with an error response, and returns one registered response per transaction.

## Interface
- MAX_BURST, 4: max consecutive locked grants to one master while the other master is requesting; legal range 1..15.
- clk  in  1  system clock; all logic on rising edge.
- reset_n  in  1  synchronous, active-low reset.
- m0_req / m1_req  in  1  transaction request; held with its payload until ack.
- m0_addr / m1_addr  in  32  byte address.
- m0_wdata / m1_wdata  in  32  write data.
- m0_we / m1_we  in  1  1 = write, 0 = read.
- m0_lock / m1_lock  in  1  request to keep ownership for the next transaction.
- m0_ack / m1_ack  out  1  one-cycle response strobe.
- m0_err / m1_err  out  1  error flag; valid only with ack.
- m0_rdata / m1_rdata  out  32  read data; valid only with ack.
- br_addr  out  32  to bridge address input.
- br_wdata  out  32  to bridge write-data input.
- br_we  out  1  to bridge write enable.
- br_rdata  in  32  bridge read-data output (combinational in the bridge).
- owner  out  2  00 idle, 01 master 0, 10 master 1.

## Operation
- FSM states:
  - IDLE → ACCESS when any eligible request is present.
  - ACCESS → RESP unconditionally.
  - RESP → IDLE unconditionally.
- IDLE grant rules:
  - If the hold flag is set and the holder's req=1, grant the holder.
  - Otherwise grant the requesting master. If both request, grant the one not granted last.
  - The last-granted pointer resets to master 1, so master 0 wins the first tie.
- On grant:
  - Latch owner, addr, wdata and we.
  - Compute ok = aligned (addr[1:0]==0) and mapped: DM 0x0000–0x2FFF, T0 0x7F00–0x7F0B, T1 0x7F10–0x7F1B.
- ACCESS:
  - br_addr and br_wdata driven from the latched values.
  - br_we = latched_we & ok.
  - br_rdata captured into the response register; response is 0 when ok=0 or we=1.
- RESP:
  - The owner's ack=1, with rdata and err = ~ok.
  - The other master's ack stays 0.
- Hold/burst rules:
  - In RESP, if the owner's lock=1, set hold and increment burst_cnt.
  - If the owner's lock=0, clear hold and set burst_cnt=0.
  - When burst_cnt==MAX_BURST and the other master's req=1, clear hold and force the grant to the other master; burst_cnt returns to 0.
  - When burst_cnt==MAX_BURST and the other master is idle, burst_cnt saturates and the holder keeps ownership.
  - An ownership change always sets burst_cnt=0.
  - If the holder's req=0 in IDLE, clear hold; normal arbitration applies in the same cycle.
- Master obligations:
  - Payload stable from req until ack.
  - In the cycle after ack, either present the next transaction or drop req.
  - The arbiter samples only in IDLE.
- Outside ACCESS, br_addr, br_wdata and br_we are 0.

## Timing
- Latency: req sampled in IDLE at cycle n → bridge access at n+1 → ack and rdata at n+2.
- Throughput: one transaction per 3 cycles.
- Reset values: all acks, errs and rdatas = 0; br_* = 0; owner = 00; state = IDLE; hold = 0; burst_cnt = 0; last-granted = master 1.
- Reset mid-operation (any state): the next cycle shows reset values. The in-flight transaction is dropped with no ack and no bridge write beyond an ACCESS cycle already completed.
- A req asserted during ACCESS or RESP is not seen until the following IDLE.
- Simultaneous requests with hold clear: strict alternation.
- br_we is asserted for exactly one cycle per accepted, valid write.

## Structure
- Shared package bridge_pkg holds:
  - address-map constants (DM_LO/DM_HI, T0_LO/T0_HI, T1_LO/T1_HI);
  - the state enum (IDLE/ACCESS/RESP);
  - the owner encoding.
- One combinational sub-module, bridge_addr_check: addr → ok (aligned & mapped). It is reusable by the bridge itself.
- Everything else stays in bridge_arbiter: FSM, grant logic, burst counter, response register.

## Test plan
- M0 read at 0x7F04, bridge returns 0x12345678:
  - cycle 1: br_addr=0x7F04, br_we=0;
  - cycle 2: m0_ack=1, m0_rdata=0x12345678, m0_err=0.
- Both masters write continuously (M0 → 0x0010, M1 → 0x7F10), no lock:
  - grants alternate M0, M1, M0, …;
  - one br_we pulse each; owner toggles 01/10.
- M1 write to 0x7F0C (hole) and M0 read of 0x0002 (misaligned):
  - br_we stays 0;
  - ack with err=1 and rdata=0 for both.
- MAX_BURST=4, M0 lock=1 and M1 req held:
  - M0 receives exactly 4 acks, then M1 is granted;
  - with M1 idle instead, M0 keeps ownership indefinitely.
- reset_n low during ACCESS of an M1 write:
  - no m1_ack; all outputs 0 the next cycle;
  - after release, a pending tie goes to M0 first.
- M0 holder drops req while hold is set and M1 requests:
  - M1 is granted in that same IDLE cycle; burst_cnt = 0.
